// File: rtl/bp_me_pkg.sv
// Shared types and width helpers for the BedRock memory-endpoint burst blocks.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_half_paddr_cfg
    } bp_params_e;

    typedef enum logic {
        e_idle,
        e_stream
    } bp_me_burst_state_e;

    localparam int unsigned bedrock_msg_type_width_gp = 4;
    localparam int unsigned bedrock_subop_width_gp    = 4;
    localparam int unsigned bedrock_size_width_gp     = 3;

    function automatic int unsigned bp_paddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_half_paddr_cfg: return 32;
            default:             return 40;
        endcase
    endfunction

    // Must stay in step with the field list of the header struct in the arbiter.
    function automatic int unsigned bp_bedrock_header_width(input int unsigned paddr_w,
                                                            input int unsigned payload_w);
        return payload_w + bedrock_size_width_gp + paddr_w
             + bedrock_subop_width_gp + bedrock_msg_type_width_gp;
    endfunction

    function automatic int unsigned rr_ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_me_rr_picker.sv
// Round-robin picker: first asserted request at or after i_ptr, wrapping at num_inputs_p-1.
module bp_me_rr_picker
    import bp_me_pkg::*;
#(
    parameter  int unsigned num_inputs_p = 2,
    localparam int unsigned ptr_width_lp = rr_ptr_width(num_inputs_p)
) (
    input  logic [num_inputs_p-1:0] i_req,
    input  logic [ptr_width_lp-1:0] i_ptr,
    output logic [num_inputs_p-1:0] o_grant_oh,
    output logic [ptr_width_lp-1:0] o_grant_id,
    output logic                    o_any
);

    localparam int unsigned sum_width_lp = ptr_width_lp + 1;

    logic [sum_width_lp-1:0] w_sum;
    logic                    w_found;

    assign o_any = |i_req;

    // Walk the ring starting at the pointer; the first hit wins.
    always_comb begin
        o_grant_oh = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        w_sum      = '0;
        for (int unsigned k = 0; k < num_inputs_p; k++) begin
            w_sum = {1'b0, i_ptr} + sum_width_lp'(k);
            if (w_sum >= sum_width_lp'(num_inputs_p)) begin
                w_sum = w_sum - sum_width_lp'(num_inputs_p);
            end
            if (!w_found && i_req[w_sum[ptr_width_lp-1:0]]) begin
                o_grant_id                       = w_sum[ptr_width_lp-1:0];
                o_grant_oh[w_sum[ptr_width_lp-1:0]] = 1'b1;
                w_found                          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_me_burst_arbiter.sv
// N:1 BedRock Burst arbiter: round-robin header arbitration, then the winner owns
// the data channel until its last beat. Outputs are combinational (zero latency).
module bp_me_burst_arbiter
    import bp_me_pkg::*;
#(
    parameter  bp_params_e  bp_params_p        = e_bp_default_cfg,
    parameter  int unsigned data_width_p       = 64,
    parameter  int unsigned payload_width_p    = 16,
    parameter  int unsigned num_inputs_p       = 2,
    localparam int unsigned paddr_width_lp     = bp_paddr_width(bp_params_p),
    localparam int unsigned bp_header_width_lp = bp_bedrock_header_width(paddr_width_lp, payload_width_p),
    localparam int unsigned ptr_width_lp       = rr_ptr_width(num_inputs_p)
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,

    input  logic [num_inputs_p*bp_header_width_lp-1:0] in_msg_header_i,
    input  logic [num_inputs_p-1:0]                    in_msg_header_v_i,
    input  logic [num_inputs_p-1:0]                    in_msg_has_data_i,
    output logic [num_inputs_p-1:0]                    in_msg_header_ready_and_o,
    input  logic [num_inputs_p*data_width_p-1:0]       in_msg_data_i,
    input  logic [num_inputs_p-1:0]                    in_msg_data_v_i,
    input  logic [num_inputs_p-1:0]                    in_msg_last_i,
    output logic [num_inputs_p-1:0]                    in_msg_data_ready_and_o,

    output logic [bp_header_width_lp-1:0]              out_msg_header_o,
    output logic                                       out_msg_header_v_o,
    output logic                                       out_msg_has_data_o,
    input  logic                                       out_msg_header_ready_and_i,
    output logic [data_width_p-1:0]                    out_msg_data_o,
    output logic                                       out_msg_data_v_o,
    output logic                                       out_msg_last_o,
    input  logic                                       out_msg_data_ready_and_i
);

    typedef struct packed {
        logic [payload_width_p-1:0]           payload;
        logic [bedrock_size_width_gp-1:0]     size;
        logic [paddr_width_lp-1:0]            addr;
        logic [bedrock_subop_width_gp-1:0]    subop;
        logic [bedrock_msg_type_width_gp-1:0] msg_type;
    } bp_bedrock_header_s;

    bp_bedrock_header_s        w_in_hdr  [num_inputs_p];
    logic [data_width_p-1:0]   w_in_data [num_inputs_p];

    logic [num_inputs_p-1:0]   w_grant_oh;
    logic [ptr_width_lp-1:0]   w_grant_id;
    logic [ptr_width_lp-1:0]   w_ptr_inc;
    logic                      w_any;

    bp_me_burst_state_e        state_r,  state_n;
    logic [ptr_width_lp-1:0]   rr_ptr_r, rr_ptr_n;
    logic [ptr_width_lp-1:0]   owner_r,  owner_n;

    always_comb begin
        for (int unsigned i = 0; i < num_inputs_p; i++) begin
            w_in_hdr[i]  = bp_bedrock_header_s'(in_msg_header_i[i*bp_header_width_lp +: bp_header_width_lp]);
            w_in_data[i] = in_msg_data_i[i*data_width_p +: data_width_p];
        end
    end

    bp_me_rr_picker #(
        .num_inputs_p (num_inputs_p)
    ) u_picker (
        .i_req      (in_msg_header_v_i),
        .i_ptr      (rr_ptr_r),
        .o_grant_oh (w_grant_oh),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    assign w_ptr_inc = (w_grant_id == ptr_width_lp'(num_inputs_p - 1))
                     ? '0 : w_grant_id + ptr_width_lp'(1);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= e_idle;
            rr_ptr_r <= '0;
            owner_r  <= '0;
        end else begin
            state_r  <= state_n;
            rr_ptr_r <= rr_ptr_n;
            owner_r  <= owner_n;
        end
    end

    always_comb begin
        state_n                   = state_r;
        rr_ptr_n                  = rr_ptr_r;
        owner_n                   = owner_r;
        out_msg_header_o          = '0;
        out_msg_header_v_o        = 1'b0;
        out_msg_has_data_o        = 1'b0;
        in_msg_header_ready_and_o = '0;
        out_msg_data_o            = '0;
        out_msg_data_v_o          = 1'b0;
        out_msg_last_o            = 1'b0;
        in_msg_data_ready_and_o   = '0;

        case (state_r)
            e_idle: begin
                out_msg_header_v_o        = w_any;
                out_msg_header_o          = w_in_hdr[w_grant_id];
                out_msg_has_data_o        = in_msg_has_data_i[w_grant_id];
                in_msg_header_ready_and_o = w_grant_oh & {num_inputs_p{out_msg_header_ready_and_i}};
                if (w_any && out_msg_header_ready_and_i) begin
                    rr_ptr_n = w_ptr_inc;
                    if (in_msg_has_data_i[w_grant_id]) begin
                        owner_n = w_grant_id;
                        state_n = e_stream;
                    end
                end
            end
            e_stream: begin
                out_msg_data_o                   = w_in_data[owner_r];
                out_msg_data_v_o                 = in_msg_data_v_i[owner_r];
                out_msg_last_o                   = in_msg_last_i[owner_r];
                in_msg_data_ready_and_o[owner_r] = out_msg_data_ready_and_i;
                if (in_msg_data_v_i[owner_r] && out_msg_data_ready_and_i && in_msg_last_i[owner_r]) begin
                    state_n = e_idle;
                end
            end
            default: state_n = e_idle;
        endcase

        // Outputs are forced quiet while reset is held, not just after the first edge.
        if (!reset_n_i) begin
            out_msg_header_o          = '0;
            out_msg_header_v_o        = 1'b0;
            out_msg_has_data_o        = 1'b0;
            in_msg_header_ready_and_o = '0;
            out_msg_data_o            = '0;
            out_msg_data_v_o          = 1'b0;
            out_msg_last_o            = 1'b0;
            in_msg_data_ready_and_o   = '0;
        end
    end

endmodule

// File: tb/tb_bp_me_burst_arbiter.sv
// Bench for bp_me_burst_arbiter: directed scenarios with literal expectations, then
// randomized Burst traffic checked every cycle against a queue-free ownership model.
module tb_bp_me_burst_arbiter;
    import bp_me_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned PL = 8;
    localparam int unsigned HW = bp_bedrock_header_width(bp_paddr_width(e_bp_default_cfg), PL);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [HW-1:0]   hdr [N];
    logic [DW-1:0]   dat [N];
    logic [N-1:0]    hv, hd, dv, lst;
    logic            out_hr, out_dr;
    logic [N*HW-1:0] hdr_bus;
    logic [N*DW-1:0] dat_bus;

    logic [N-1:0]    o_hr, o_dr;
    logic [HW-1:0]   out_hdr;
    logic            out_hv, out_hd, out_dv, out_last;
    logic [DW-1:0]   out_dat;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            hdr_bus[i*HW +: HW] = hdr[i];
            dat_bus[i*DW +: DW] = dat[i];
        end
    end

    bp_me_burst_arbiter #(
        .bp_params_p     (e_bp_default_cfg),
        .data_width_p    (DW),
        .payload_width_p (PL),
        .num_inputs_p    (N)
    ) dut (
        .clk_i                      (clk),
        .reset_n_i                  (rst_n),
        .in_msg_header_i            (hdr_bus),
        .in_msg_header_v_i          (hv),
        .in_msg_has_data_i          (hd),
        .in_msg_header_ready_and_o  (o_hr),
        .in_msg_data_i              (dat_bus),
        .in_msg_data_v_i            (dv),
        .in_msg_last_i              (lst),
        .in_msg_data_ready_and_o    (o_dr),
        .out_msg_header_o           (out_hdr),
        .out_msg_header_v_o         (out_hv),
        .out_msg_has_data_o         (out_hd),
        .out_msg_header_ready_and_i (out_hr),
        .out_msg_data_o             (out_dat),
        .out_msg_data_v_o           (out_dv),
        .out_msg_last_o             (out_last),
        .out_msg_data_ready_and_i   (out_dr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: m_owner = -1 means no one owns the data channel.
    int m_owner = -1, m_ptr = 0, nx_owner = -1, nx_ptr = 0;

    always @(negedge clk) begin : model_cmp
        int           g;
        logic [N-1:0] e_hr, e_dr;
        logic         e_hv, e_dv;
        e_hr = '0; e_dr = '0; e_hv = 1'b0; e_dv = 1'b0; g = -1;
        nx_owner = m_owner; nx_ptr = m_ptr;
        if (!rst_n) begin
            nx_owner = -1; nx_ptr = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && hv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
                e_hv    = 1'b1;
                e_hr[g] = out_hr;
                chk("m_hdr", 64'(out_hdr), 64'(hdr[g]));
                chk("m_has_data", 64'(out_hd), 64'(hd[g]));
                if (out_hr) begin
                    nx_ptr = (g + 1) % N;
                    if (hd[g]) nx_owner = g;
                end
            end
        end else begin
            e_dv          = dv[m_owner];
            e_dr[m_owner] = out_dr;
            if (e_dv) begin
                chk("m_data", 64'(out_dat), 64'(dat[m_owner]));
                chk("m_last", 64'(out_last), 64'(lst[m_owner]));
                if (out_dr && lst[m_owner]) nx_owner = -1;
            end
        end
        chk("m_hdr_v", 64'(out_hv), 64'(e_hv));
        chk("m_hdr_ready", 64'(o_hr), 64'(e_hr));
        chk("m_data_v", 64'(out_dv), 64'(e_dv));
        chk("m_data_ready", 64'(o_dr), 64'(e_dr));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
        end else begin
            m_owner <= nx_owner;
            m_ptr   <= nx_ptr;
        end
    end

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    logic [DW-1:0] beat [4];
    logic [N-1:0]  onehot;
    int            sent_d3, cyc;
    bit            hp [N], dp [N];
    int            nb [N], sent [N], wait_g [N];
    logic [N-1:0]  hs_h, hs_d;
    logic          hs_out_h;

    initial begin
        hv = '0; hd = '0; dv = '0; lst = '0; out_hr = 1'b0; out_dr = 1'b0;
        for (int i = 0; i < N; i++) begin
            hdr[i] = '0;
            dat[i] = '0;
        end
        for (int b = 0; b < 4; b++) beat[b] = DW'(32'hB000_0000 + 32'(b) * 32'h0101_0101);

        repeat (3) @(posedge clk);
        sample();
        chk("rst_hdr_v", 64'(out_hv), 64'(0));
        chk("rst_hdr_ready", 64'(o_hr), 64'(0));
        @(negedge clk); #3 rst_n = 1'b1;

        // Two no-data headers from 0 and 1 with ready held high.
        adv();
        hdr[0] = HW'({$urandom(), $urandom()});
        hdr[1] = HW'({$urandom(), $urandom()});
        hv = 4'b0011; hd = '0; out_hr = 1'b1; out_dr = 1'b1;
        sample();
        chk("d1_hdr_v", 64'(out_hv), 64'(1));
        chk("d1_hdr0", 64'(out_hdr), 64'(hdr[0]));
        chk("d1_ready0", 64'(o_hr), 64'(4'b0001));
        adv(); hv = 4'b0010;
        sample();
        chk("d1_hdr1", 64'(out_hdr), 64'(hdr[1]));
        chk("d1_ready1", 64'(o_hr), 64'(4'b0010));
        adv(); hv = '0;
        sample();
        chk("d1_quiet", 64'(out_hv), 64'(0));

        // Pointer is 2: requester 3 (4 beats) beats requester 0; 1 sends stray data.
        adv();
        hdr[3] = HW'({$urandom(), $urandom()});
        hdr[0] = HW'({$urandom(), $urandom()});
        hv = 4'b1001; hd = 4'b1000;
        dat[3] = beat[0]; dv = 4'b1010; dat[1] = DW'(32'hDEAD_BEEF);
        sample();
        chk("d2_hdr3", 64'(out_hdr), 64'(hdr[3]));
        chk("d2_has_data", 64'(out_hd), 64'(1));
        chk("d2_ready3", 64'(o_hr), 64'(4'b1000));
        chk("d2_early_data_ready", 64'(o_dr), 64'(0));
        adv(); hv = 4'b0001;
        for (int b = 0; b < 4; b++) begin
            dat[3] = beat[b]; lst[3] = (b == 3);
            sample();
            chk("d2_hdr_v_off", 64'(out_hv), 64'(0));
            chk("d2_beat", 64'(out_dat), 64'(beat[b]));
            chk("d2_last", 64'(out_last), 64'(b == 3));
            chk("d2_data_ready", 64'(o_dr), 64'(4'b1000));
            adv();
        end
        dv = '0; lst = '0;
        sample();
        chk("d2_hdr0_next", 64'(out_hdr), 64'(hdr[0]));
        chk("d2_ready0_next", 64'(o_hr), 64'(4'b0001));
        adv(); hv = '0;

        // Pointer is 1: requester 2 streams 4 beats under a toggling data ready.
        hdr[2] = HW'({$urandom(), $urandom()});
        hv = 4'b0100; hd = 4'b0100; out_dr = 1'b0;
        sample();
        chk("d3_hdr_ready", 64'(o_hr), 64'(4'b0100));
        adv(); hv = '0;
        sent_d3 = 0; cyc = 0;
        while (sent_d3 < 4 && cyc < 40) begin
            dat[2] = beat[sent_d3]; dv[2] = 1'b1; lst[2] = (sent_d3 == 3);
            out_dr = cyc[0];
            sample();
            chk("d3_data_ready", 64'(o_dr), 64'(out_dr ? 4'b0100 : 4'b0000));
            chk("d3_beat", 64'(out_dat), 64'(beat[sent_d3]));
            if (o_dr[2]) sent_d3++;
            adv();
            cyc++;
        end
        chk("d3_beat_count", 64'(sent_d3), 64'(4));
        dv = '0; lst = '0; out_dr = 1'b1;

        // Pointer is 3: requester 1 streams, reset drops after 2 of 4 beats.
        hdr[1] = HW'({$urandom(), $urandom()});
        hv = 4'b0010; hd = 4'b0010; dv = 4'b0010; dat[1] = beat[0];
        sample();
        chk("d4_hdr_ready", 64'(o_hr), 64'(4'b0010));
        chk("d4_early_data_ready", 64'(o_dr), 64'(0));
        adv(); hv = 4'b1000; hd = 4'b0010;
        for (int b = 0; b < 2; b++) begin
            dat[1] = beat[b];
            sample();
            chk("d4_beat", 64'(out_dat), 64'(beat[b]));
            adv();
        end
        dat[1] = beat[2];
        sample();
        chk("d4_pre_reset_v", 64'(out_dv), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("d4_rst_hdr_v", 64'(out_hv), 64'(0));
        chk("d4_rst_data_v", 64'(out_dv), 64'(0));
        chk("d4_rst_data", 64'(out_dat), 64'(0));
        chk("d4_rst_hdr_ready", 64'(o_hr), 64'(0));
        chk("d4_rst_data_ready", 64'(o_dr), 64'(0));
        dv = '0; hv = '0; hd = '0;
        @(negedge clk); #3 rst_n = 1'b1;

        // Everyone requests after release: grants 0,1,2,3,0.
        adv(); hv = 4'b1111; out_hr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            onehot = '0; onehot[k % 4] = 1'b1;
            chk("d5_grant", 64'(o_hr), 64'(onehot));
            adv();
        end
        hv = '0;

        // Randomized traffic.
        for (int i = 0; i < N; i++) begin
            hp[i] = 1'b0; dp[i] = 1'b0; nb[i] = 1; sent[i] = 0; wait_g[i] = 0;
        end
        hs_h = '0; hs_d = '0; hs_out_h = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            adv();
            for (int i = 0; i < N; i++) begin
                if (hs_out_h && hp[i] && !hs_h[i]) wait_g[i]++;
                if (hs_h[i]) begin
                    hp[i] = 1'b0;
                    chk("starvation_bound", 64'(wait_g[i] <= N - 1), 64'(1));
                end
                if (hs_d[i]) begin
                    if (lst[i]) dp[i] = 1'b0;
                    sent[i]++;
                    dat[i] = DW'($urandom());
                end
                if (!hp[i] && !dp[i] && $urandom_range(0, 2) == 0) begin
                    hp[i]     = 1'b1;
                    hdr[i]    = HW'({$urandom(), $urandom()});
                    hd[i]     = 1'($urandom_range(0, 1));
                    dp[i]     = hd[i];
                    nb[i]     = int'($urandom_range(1, 4));
                    sent[i]   = 0;
                    wait_g[i] = 0;
                    dat[i]    = DW'($urandom());
                end
                hv[i]  = hp[i];
                dv[i]  = dp[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
                lst[i] = dp[i] ? (sent[i] == nb[i] - 1) : 1'($urandom_range(0, 1));
            end
            out_hr = ($urandom_range(0, 3) != 0);
            out_dr = ($urandom_range(0, 3) != 0);
            @(negedge clk); #2;
            hs_h     = hv & o_hr;
            hs_d     = dv & o_dr;
            hs_out_h = out_hv & out_hr;
        end

        adv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_me_burst_arbiter.md
BP_ME_BURST_ARBITER -- requirements
Module: bp_me_burst_arbiter

Interface
REQ-001 Parameter bp_params_p, default e_bp_default_cfg, supplies paddr_width_p and the BedRock header typedef.
REQ-002 Parameter data_width_p, no default, is the data beat width.
REQ-003 Parameter payload_width_p, no default, is the BedRock header payload width.
REQ-004 Parameter num_inputs_p, default 2, is the number of Burst requesters; legal range 2..8.
REQ-005 Port clk_i, input, 1, is the single clock.
REQ-006 Port reset_n_i, input, 1, is the asynchronous active-low reset.
REQ-007 Port in_msg_header_i, input, num_inputs_p*bp_header_width_lp, holds the per-requester headers.
REQ-008 Port in_msg_header_v_i, input, num_inputs_p, holds the per-requester header valids.
REQ-009 Port in_msg_has_data_i, input, num_inputs_p, flags headers that are followed by data beats.
REQ-010 Port in_msg_header_ready_and_o, output, num_inputs_p, is the per-requester header ready.
REQ-011 Port in_msg_data_i, input, num_inputs_p*data_width_p, holds the per-requester data beats.
REQ-012 Port in_msg_data_v_i, input, num_inputs_p, holds the data valids.
REQ-013 Port in_msg_last_i, input, num_inputs_p, marks each requester's last beat.
REQ-014 Port in_msg_data_ready_and_o, output, num_inputs_p, is the per-requester data ready.
REQ-015 Ports out_msg_header_o, out_msg_header_v_o, out_msg_has_data_o and out_msg_header_ready_and_i form the single Burst header channel.
REQ-016 Ports out_msg_data_o, out_msg_data_v_o, out_msg_last_o and out_msg_data_ready_and_i form the single Burst data channel.
REQ-017 All channels use ready-valid-and handshakes.

Function
REQ-018 The FSM has two states: e_idle (header arbitration) and e_stream (data owned by one requester).
REQ-019 In e_idle, grant is the first requester with header_v set, searching round-robin from rr_ptr_r upward with wrap at num_inputs_p-1 to 0.
REQ-020 In e_idle, out_msg_header_v_o = OR of in_msg_header_v_i, and header/has_data are muxed from the grant combinationally (zero latency).
REQ-021 In e_idle, in_msg_header_ready_and_o[grant] = out_msg_header_ready_and_i and all other bits are 0.
REQ-022 Grant selection is independent of out_msg_header_ready_and_i (no valid-on-ready dependency).
REQ-023 On an output header handshake, rr_ptr_r <= (grant+1) mod num_inputs_p.
REQ-024 On an output header handshake with has_data=1, owner_r <= grant and the FSM goes to e_stream; with has_data=0 it stays in e_idle.
REQ-025 In e_stream, out_msg_header_v_o = 0 and all in_msg_header_ready_and_o = 0.
REQ-026 In e_stream, data, data_v and last pass through from owner_r, and in_msg_data_ready_and_o[owner_r] = out_msg_data_ready_and_i; other bits are 0.
REQ-027 In e_idle, out_msg_data_v_o = 0 and all in_msg_data_ready_and_o = 0.
REQ-028 Data beats presented before their header handshake are not accepted.
REQ-029 An output data handshake with last=1 returns the FSM to e_idle; the next header may issue on the following cycle.
REQ-030 Requester data valids other than owner_r's are ignored and never stall the owner.
REQ-031 No beat is dropped or duplicated, and the beat count per message is set solely by the requester's last.
REQ-032 A requester holding header_v while losing arbitration keeps its header, and is served within num_inputs_p header grants.

Reset
REQ-033 Asserting reset_n_i low asynchronously forces state=e_idle, rr_ptr_r=0 and owner_r=0.
REQ-034 During reset, all valid and ready outputs are 0.
REQ-035 Reset during e_stream abandons the message with no further beats forwarded.
REQ-036 Reset deassertion is synchronous to clk_i (external synchronizer), and the first grant is possible in the first cycle after release.

Structure
REQ-037 The state enum (e_idle, e_stream) is declared in bp_me_pkg.
REQ-038 The header struct comes from the bp_bedrock_if declaration macros.
REQ-039 Round-robin selection is one sub-module, bp_me_rr_picker (requests, ptr -> one-hot grant, encoded grant, any).
REQ-040 The RTL is expected at 150-300 lines.

Verification
REQ-041 Scenario: reset, then inputs 0 and 1 present no-data headers together with ready=1 -> grants 0 then 1 on consecutive cycles, and rr_ptr ends at 0.
REQ-042 Scenario: input 1 sends a has_data header with 4 beats while input 0 requests -> header 1 issues, then 4 beats from 1 with last on beat 4, then header 0 on the next cycle.
REQ-043 Scenario: in e_stream, out_msg_data_ready_and_i toggles every cycle -> exactly 4 beats transfer in order, and in_msg_data_ready_and_o mirrors ready for the owner only.
REQ-044 Scenario: with num_inputs_p=4, all requesting continuously -> grant order is 0,1,2,3,0 with no starvation.
REQ-045 Scenario: the non-owner asserts data_v during a stream -> its ready stays 0 and its data never appears at the output.
REQ-046 Scenario: reset_n_i drops mid-stream after 2 of 4 beats -> all outputs 0 immediately, and after release the FSM is in e_idle with rr_ptr=0.
